// File: rtl/rr_stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux_pkg
// Brief    : Shared constants and helpers for the round-robin stream mux.
// Revision : 1.0 - initial release
// ============================================================================
package rr_stream_mux_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    // Ceiling log2, usable in parameter port lists.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating priority encoder; first request at or
//            above ptr wins, wrapping from N-1 to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    logic [SELW:0] w_idx;

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        w_idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr} + (SELW + 1)'(k);
            if (w_idx >= (SELW + 1)'(N)) begin
                w_idx = w_idx - (SELW + 1)'(N);
            end
            if (req[w_idx[SELW-1:0]]) begin
                grant_idx = w_idx[SELW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux
// Brief    : N-channel valid/ready stream mux with round-robin or forced
//            select and one registered output stage. Optional packet lock
//            via RR_STREAM_MUX_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int WIDTH = c_DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
`endif
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [SELW-1:0]    force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    output logic               out_last,
`endif
    input  logic               out_ready
);

    logic [WIDTH-1:0] w_lanes [N];
    logic [SELW-1:0]  w_arb_idx;
    logic             w_arb_vld;
    logic [SELW-1:0]  w_win;
    logic             w_grant;
    logic             w_rr_mode;
    logic             w_slot_free;
    logic             w_force_ok;
    logic             w_accept;
    logic [SELW-1:0]  w_ptr_next;

    logic [SELW-1:0]  r_rr_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_sel;
    logic             r_out_valid;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_lanes[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .grant_idx (w_arb_idx),
        .grant_vld (w_arb_vld)
    );

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_force_ok  = {1'b0, force_sel} < (SELW + 1)'(N);

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    logic            r_lock;
    logic [SELW-1:0] r_lock_ch;
    logic            r_lock_rr;
    logic            r_out_last;
`endif

    // Grant source priority: active packet lock, then forced select, then round-robin.
    always_comb begin
        w_win     = w_arb_idx;
        w_grant   = w_arb_vld;
        w_rr_mode = 1'b1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        if (r_lock) begin
            w_win     = r_lock_ch;
            w_grant   = in_valid[r_lock_ch];
            w_rr_mode = r_lock_rr;
        end else
`endif
        if (force_en) begin
            w_win     = force_sel;
            w_grant   = w_force_ok && in_valid[force_sel];
            w_rr_mode = 1'b0;
        end
    end

    assign w_accept   = w_grant && w_slot_free && !rst;
    assign w_ptr_next = (w_win == SELW'(N - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_rr_ptr    <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            r_out_last  <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_ch   <= '0;
            r_lock_rr   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lanes[w_win];
            r_out_sel   <= w_win;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            r_out_last  <= in_last[w_win];
            r_lock      <= !in_last[w_win];
            r_lock_ch   <= w_win;
            r_lock_rr   <= w_rr_mode;
            // The pointer only moves once the whole packet has gone through.
            if (in_last[w_win] && w_rr_mode) begin
                r_rr_ptr <= w_ptr_next;
            end
`else
            if (w_rr_mode) begin
                r_rr_ptr <= w_ptr_next;
            end
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule
`default_nettype wire

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N-channel stream multiplexer, successor to the fixed mux2/4/8/16 selectors in the datapath.
- Per-channel valid/ready handshake, round-robin arbitration and a static forced-select mode.
- One registered output stage.
- Sits between multi-cycle CPU request sources (fetch, load/store, debug) and a shared consumer such as the memory port.

Parameters:
WIDTH, 32, data bits per channel
N, 4, number of input channels (N >= 2)
SELW, $clog2(N), select/index width (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel request valid
in_ready  output  N  per-channel accept
force_en  input  1  1 = static mux mode, 0 = round-robin
force_sel  input  SELW  channel used when force_en=1
out_data  output  WIDTH  registered selected data
out_sel  output  SELW  index of channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  downstream accept

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is combinational and is 0 while rst=1.
- slot_free = !out_valid || out_ready. A transfer on either side occurs when valid && ready in the same cycle.
- Grant, round-robin (force_en=0):
  - Winner is the first i with in_valid[i]=1, scanning from rr_ptr upward with wrap at N-1 -> 0.
  - in_ready[i] = slot_free && (i == winner); all other in_ready bits are 0.
- Grant, forced (force_en=1):
  - Winner = force_sel if in_valid[force_sel]=1, otherwise no grant.
  - force_sel >= N gives no grant and all in_ready=0.
- On accept: out_data <= selected lane, out_sel <= winner, out_valid <= 1.
  - Round-robin mode only: rr_ptr <= (winner+1) mod N.
  - Forced mode leaves rr_ptr unchanged.
- If out_valid && out_ready and there is no new accept: out_valid <= 0. out_data and out_sel hold their values.
- Latency: 1 cycle from input accept to out_valid. Throughput: 1 beat/cycle, including simultaneous drain and refill.
- Stall: while out_valid && !out_ready, out_data and out_sel stay stable and all in_ready=0.
- Switching force_en mid-stream takes effect on the next grant decision. The beat in the output register is unaffected.
- rst asserted with out_valid=1 discards the beat. This is legal; no partial-state retention.
- No combinational path from out_ready to out_data. in_ready depends combinationally on out_ready.

Optional Feature:
Macro RR_STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N) and out_last (output, 1; reset 0, registered alongside out_data).
  - After an accepted beat with in_last[winner]=0, the grant locks to that channel in both modes. Other channels get in_ready=0, and force_sel/force_en changes are ignored.
  - The lock releases after a beat with in_last=1 is accepted. rr_ptr advances only on release.
  - rst clears the lock.
- Undefined: no last ports, arbitration every beat as above.

Decomposition:
- Package rr_stream_mux_pkg: no typedefs required. Holds a clog2 constant function and a localparam for the default width.
- Sub-module rr_arbiter (N param): inputs req[N], ptr[SELW]; outputs grant_idx[SELW], grant_vld. Purely combinational rotate / priority-encode.
- rr_stream_mux owns the output register, pointer, lock and force logic.

Test Plan:
- N=4, WIDTH=8, force_en=0, all in_valid=1, out_ready=1, lanes 0xA0..0xA3 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0, 1-cycle latency.
- Only in_valid[2]=1, data 0x5C, out_ready=0 for 3 cycles -> out_valid=1 with 0x5C and out_sel=2 held stable for 3 cycles, in_ready=0000; out_ready=1 -> next beat accepted the same cycle.
- force_en=1, force_sel=3, in_valid=1111 -> only lane 3 is granted every cycle; rr_ptr unchanged. force_sel=3 with in_valid[3]=0 -> in_ready=0000 and out_valid drops to 0.
- rst pulsed while out_valid=1, data 0x77 -> next cycle out_valid=0, out_data=0x00, out_sel=0. The arbiter then grants ch0 first with all lanes valid.
- RR_STREAM_MUX_PKT_LOCK_EN: ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 are valid -> 3 consecutive out_sel=1, then out_sel=2.
- Back-to-back with out_ready toggling 1,0,1,0 -> no beat duplicated or dropped; scoreboard count equals the accepted input count.
